// File: rtl/seq_carry_select_adder.sv
// seq_carry_select_adder
// Multi-cycle carry-select adder. Each cycle one BLOCK-bit slice of the
// operands is added twice (carry-in 0 and carry-in 1) and the registered
// block carry picks the right result, i.e. the carry-select mux stage is
// unrolled in time.
//
// Handshake rules (both sides): a transfer happens on a rising clk edge
// where valid and ready are both 1. A producer holds its valid and payload
// stable until that edge. in_ready is high only in IDLE and out_valid only in
// DONE, both decoded from the state register, so neither ever depends
// combinationally on an input.
module seq_carry_select_adder #(
   parameter int WIDTH = 32,
   parameter int BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow
);

   localparam int NBLK = WIDTH / BLOCK;
   localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;

   // Slices must tile the operand exactly.
   generate
      if ((BLOCK < 1) || (WIDTH % BLOCK != 0)) begin : g_bad_block
         $error("seq_carry_select_adder: WIDTH must be a multiple of BLOCK");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // state is kept as a named signal so assertions and checkers can bind to it.
   state_t state;
   state_t state_nxt;

   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             carry_r;
   logic [IDXW-1:0]  idx;

   logic [BLOCK-1:0] a_s;
   logic [BLOCK-1:0] b_s;
   logic [BLOCK-1:0] s0;
   logic [BLOCK-1:0] s1;
   logic [BLOCK-1:0] s_sel;
   logic             c0;
   logic             c1;
   logic             carry_nxt;
   logic             last;
   int unsigned      base;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: accept in IDLE, walk NBLK slices, wait for consumer.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = CALC;
         CALC:    if (last) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from state only.
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Current slice: both carry hypotheses and the block-carry select.
   always_comb begin
      base      = 32'(idx) * 32'(BLOCK);
      last      = (idx == IDXW'(NBLK - 1));
      a_s       = a_r[base +: BLOCK];
      b_s       = b_r[base +: BLOCK];
      {c0, s0}  = {1'b0, a_s} + {1'b0, b_s};
      {c1, s1}  = {1'b0, a_s} + {1'b0, b_s} + {{BLOCK{1'b0}}, 1'b1};
      s_sel     = carry_r ? s1 : s0;
      carry_nxt = c0 | (carry_r & c1);
   end

   // Datapath: latch operands on accept, build the sum one slice per cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_r      <= '0;
         b_r      <= '0;
         carry_r  <= 1'b0;
         idx      <= '0;
         sum      <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r     <= a;
                  b_r     <= b;
                  carry_r <= c_in;
                  idx     <= '0;
               end
            end
            CALC: begin
               sum[base +: BLOCK] <= s_sel;
               carry_r            <= carry_nxt;
               idx                <= idx + IDXW'(1);
               if (last) begin
                  c_out    <= carry_nxt;
                  // Last slice holds the MSB, so s_sel's top bit is sum[MSB].
                  overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                              (s_sel[BLOCK-1] != a_r[WIDTH-1]);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_carry_select_adder.sv
// Testbench for seq_carry_select_adder: directed cases on the BLOCK=4
// instance plus randomized scoreboard runs on BLOCK=4, 8 and 32 instances.
module tb_seq_carry_select_adder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  in_valid = '0;
   logic [2:0]  out_ready = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        c_in = 1'b0;
   wire  [2:0]  in_ready;
   wire  [2:0]  out_valid;
   wire  [2:0]  c_out;
   wire  [2:0]  overflow;
   wire  [31:0] sum0;
   wire  [31:0] sum1;
   wire  [31:0] sum2;

   int n_tests = 0;
   int n_fail  = 0;
   logic [33:0] exp_q[$];

   // clock / reset block
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   seq_carry_select_adder #(.WIDTH(32), .BLOCK(4)) u_b4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a), .b(b), .c_in(c_in), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .sum(sum0), .c_out(c_out[0]), .overflow(overflow[0]));

   seq_carry_select_adder #(.WIDTH(32), .BLOCK(8)) u_b8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(a), .b(b), .c_in(c_in), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .sum(sum1), .c_out(c_out[1]), .overflow(overflow[1]));

   seq_carry_select_adder #(.WIDTH(32), .BLOCK(32)) u_b32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .a(a), .b(b), .c_in(c_in), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .sum(sum2), .c_out(c_out[2]), .overflow(overflow[2]));

   // reference: {c_out, overflow, sum} straight from the arithmetic definition
   function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic ci);
      logic [32:0] t;
      t = {1'b0, x} + {1'b0, y} + {32'b0, ci};
      return {t[32], (x[31] == y[31]) && (t[31] != x[31]), t[31:0]};
   endfunction

   function automatic logic [33:0] get_out(input int k);
      case (k)
         0:       return {c_out[0], overflow[0], sum0};
         1:       return {c_out[1], overflow[1], sum1};
         default: return {c_out[2], overflow[2], sum2};
      endcase
   endfunction

   // driver tasks
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = '0;
      out_ready = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (get_out(k) !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_outputs inst %0d: got %h expected 0", k, get_out(k));
         end
         n_tests++;
         if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_handshake inst %0d: out_valid=%b in_ready=%b expected 0/1",
                     k, out_valid[k], in_ready[k]);
         end
      end
   endtask

   // One op on the BLOCK=4 instance: checks latency of 8 and the result.
   task automatic run_op(input logic [31:0] aa, input logic [31:0] bb, input logic cc,
                         input string name);
      logic [33:0] exp;
      int lat;
      a = aa;
      b = bb;
      c_in = cc;
      in_valid[0] = 1'b1;
      n_tests++;
      if (in_ready[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_in_ready: got %b expected 1", name, in_ready[0]);
      end
      exp_q.push_back(model(aa, bb, cc));
      @(negedge clk);
      in_valid[0] = 1'b0;
      a = $urandom();
      b = $urandom();
      c_in = 1'($urandom_range(0, 1));
      lat = 0;
      while (out_valid[0] !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      n_tests++;
      if (lat != 8) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d cycles expected 8", name, lat);
      end
      exp = exp_q.pop_front();
      n_tests++;
      if (get_out(0) !== exp) begin
         n_fail++;
         $display("FAIL %s_result: got {c,ovf,sum}=%h expected %h", name, get_out(0), exp);
      end
      out_ready[0] = 1'b1;
      @(negedge clk);
      out_ready[0] = 1'b0;
      n_tests++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_handback: out_valid=%b in_ready=%b expected 0/1",
                  name, out_valid[0], in_ready[0]);
      end
   endtask

   task automatic test_directed();
      run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, "wrap");
      run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, "ovf");
      run_op(32'h12345678, 32'h9ABCDEF0, 1'b1, "chain");
      run_op(32'h80000000, 32'h80000000, 1'b0, "neg_ovf");
   endtask

   task automatic test_hold();
      logic [33:0] exp;
      int lat;
      a = 32'hDEADBEEF;
      b = 32'h11111111;
      c_in = 1'b1;
      exp = model(a, b, c_in);
      in_valid[0] = 1'b1;
      @(negedge clk);
      a = 32'h00000005;
      b = 32'h00000007;
      c_in = 1'b0;
      lat = 0;
      while (out_valid[0] !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || get_out(0) !== exp) begin
            n_fail++;
            $display("FAIL hold_cycle%0d: out_valid=%b in_ready=%b out=%h expected 1/0/%h",
                     i, out_valid[0], in_ready[0], get_out(0), exp);
         end
         @(negedge clk);
      end
      out_ready[0] = 1'b1;
      @(negedge clk);
      out_ready[0] = 1'b0;
      in_valid[0] = 1'b0;
      n_tests++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_handback: out_valid=%b in_ready=%b expected 0/1",
                  out_valid[0], in_ready[0]);
      end
      // Nothing was accepted during DONE, so no result may appear.
      lat = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid[0] === 1'b1) lat++;
      end
      n_tests++;
      if (lat != 0) begin
         n_fail++;
         $display("FAIL hold_no_accept: out_valid seen %0d cycles expected 0", lat);
      end
   endtask

   task automatic test_reset_mid_op();
      a = 32'hCAFEF00D;
      b = 32'h12345678;
      c_in = 1'b1;
      in_valid[0] = 1'b1;
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_tests++;
      if (out_valid[0] !== 1'b0 || sum0 !== 32'h0 || in_ready[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_reset: out_valid=%b sum=%h in_ready=%b expected 0/0/1",
                  out_valid[0], sum0, in_ready[0]);
      end
      run_op(32'h00000001, 32'h00000001, 1'b0, "after_abort");
   endtask

   // random producer for instance k
   task automatic drive_rand(input int k, input int n);
      for (int i = 0; i < n; i++) begin
         int w;
         a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom();
         b = ($urandom_range(0, 7) == 0) ? 32'h7FFFFFFF : $urandom();
         c_in = 1'($urandom_range(0, 1));
         in_valid[k] = 1'b1;
         w = 0;
         while (in_ready[k] !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
         end
         n_tests++;
         if (in_ready[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_accept inst %0d: in_ready=%b expected 1 within 200 cycles",
                     k, in_ready[k]);
         end else begin
            exp_q.push_back(model(a, b, c_in));
         end
         @(negedge clk);
         in_valid[k] = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   // scoreboard consumer for instance k with random out_ready stalls
   task automatic monitor_rand(input int k, input int n);
      int got;
      int cyc;
      logic [33:0] exp;
      got = 0;
      cyc = 0;
      while (got < n && cyc < n * 100) begin
         @(negedge clk);
         cyc++;
         out_ready[k] = ($urandom_range(0, 3) != 0);
         if (out_valid[k] === 1'b1 && out_ready[k] === 1'b1) begin
            got++;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL rand_unexpected inst %0d: got %h with empty queue", k, get_out(k));
            end else begin
               exp = exp_q.pop_front();
               if (get_out(k) !== exp) begin
                  n_fail++;
                  $display("FAIL rand_result inst %0d: got %h expected %h", k, get_out(k), exp);
               end
            end
         end
      end
      @(negedge clk);
      out_ready[k] = 1'b0;
      n_tests++;
      if (got != n) begin
         n_fail++;
         $display("FAIL rand_count inst %0d: got %0d results expected %0d", k, got, n);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 3; k++) begin
         exp_q.delete();
         fork
            drive_rand(k, 1000);
            monitor_rand(k, 1000);
         join
      end
   endtask

   initial begin
      do_reset();
      test_reset();
      test_directed();
      test_hold();
      test_reset_mid_op();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
